// File: rtl/ddr1_arb_pkg.sv
// Shared state encoding, default widths and DDR1 address field layout for the port arbiter.
package ddr1_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;

  // Address is {bank, row, col}
  localparam int BA_MSB  = 24;
  localparam int ROW_MSB = 22;
  localparam int COL_MSB = 9;

endpackage

// File: rtl/ddr1_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request strictly after 'last', wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] sel,
  output logic          any
);

  localparam logic [IW-1:0] TOP = IW'(N - 1);

  logic [IW-1:0] w_idx;

  always_comb begin
    sel   = '0;
    any   = 1'b0;
    w_idx = last;
    for (int i = 0; i < N; i++) begin
      w_idx = (w_idx == TOP) ? '0 : w_idx + IW'(1);
      if (!any && req[w_idx]) begin
        sel = w_idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr1_port_arbiter.sv
// Shares one DDR1 controller port among N_PORTS requesters; fields are latched and held until completion.
// Optional DDR1_ARB_FIXED_PRIO_EN: port 0 always wins, ports 1..N-1 round-robin among themselves.
module ddr1_port_arbiter
  import ddr1_arb_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WR_HOLD    = 6,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           m_req_valid,
  input  logic [N_PORTS-1:0]           m_req_rw,
  input  logic [N_PORTS*ADDR_W-1:0]    m_req_addr,
  input  logic [N_PORTS*DATA_W-1:0]    m_req_wdata,
  output logic [N_PORTS-1:0]           m_req_accept,
  output logic [N_PORTS-1:0]           m_resp_valid,
  output logic [DATA_W-1:0]            m_resp_rdata,
  output logic                         ctl_req_valid,
  output logic                         ctl_req_rw,
  output logic [ADDR_W-1:0]            ctl_req_addr,
  output logic [DATA_W-1:0]            ctl_req_wdata,
  input  logic                         ctl_req_ack,
  input  logic                         ctl_resp_valid,
  input  logic [DATA_W-1:0]            ctl_resp_rdata,
  output logic [$clog2(N_PORTS)-1:0]   grant_id,
  output logic                         busy,
  output logic                         err
);

  localparam int IW   = $clog2(N_PORTS);
  localparam int MAXC = (RD_TIMEOUT > WR_HOLD) ? RD_TIMEOUT : WR_HOLD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_HOLD - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [IW-1:0]       r_last, r_grant;
  logic [CW-1:0]       r_cnt;
  logic [N_PORTS-1:0]  r_accept, r_resp_vld;
  logic [DATA_W-1:0]   r_rdata, r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid, r_rw, r_err;

  logic [IW-1:0]       w_sel;
  logic                w_any, w_upd_last, w_err_evt;
  logic                w_sel_rw;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef DDR1_ARB_FIXED_PRIO_EN
  logic [N_PORTS-1:0]  w_rr_req;
  logic [IW-1:0]       w_rr_sel;
  logic                w_rr_any;

  assign w_rr_req = m_req_valid & ~N_PORTS'(1);

  rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
    .req  (w_rr_req),
    .last (r_last),
    .sel  (w_rr_sel),
    .any  (w_rr_any)
  );

  // Port 0 bypasses the rotation and never moves the round-robin pointer
  assign w_sel      = m_req_valid[0] ? '0 : w_rr_sel;
  assign w_any      = m_req_valid[0] | w_rr_any;
  assign w_upd_last = ~m_req_valid[0];
`else
  rr_pick #(.N(N_PORTS), .IW(IW)) u_pick (
    .req  (m_req_valid),
    .last (r_last),
    .sel  (w_sel),
    .any  (w_any)
  );

  assign w_upd_last = 1'b1;
`endif

  always_comb begin
    w_sel_rw    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_rw    = m_req_rw[i];
        w_sel_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = m_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   if (ctl_req_ack) w_state_nxt = r_rw ? ST_WAIT_RD : ST_WAIT_WR;
      ST_WAIT_RD: if (ctl_resp_valid || r_cnt == RD_LAST) w_state_nxt = ST_IDLE;
      ST_WAIT_WR: if (r_cnt == WR_LAST) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Stray handshakes and read timeouts all latch the sticky error
  assign w_err_evt = (ctl_req_ack && r_state != ST_ISSUE)
                   || (ctl_resp_valid && r_state != ST_WAIT_RD)
                   || (r_state == ST_WAIT_RD && !ctl_resp_valid && r_cnt == RD_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= IW'(N_PORTS - 1);
      r_grant    <= '0;
      r_cnt      <= '0;
      r_accept   <= '0;
      r_resp_vld <= '0;
      r_rdata    <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_rw       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_accept   <= '0;
      r_resp_vld <= '0;
      if (w_err_evt) r_err <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_rw             <= w_sel_rw;
            r_addr           <= w_sel_addr;
            r_wdata          <= w_sel_wdata;
            r_grant          <= w_sel;
            r_accept[w_sel]  <= 1'b1;
            r_valid          <= 1'b1;
            if (w_upd_last) r_last <= w_sel;
          end
        end
        ST_ISSUE: begin
          if (ctl_req_ack) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_WAIT_RD: begin
          if (ctl_resp_valid) begin
            r_rdata             <= ctl_resp_rdata;
            r_resp_vld[r_grant] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_WR: r_cnt <= r_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  assign m_req_accept  = r_accept;
  assign m_resp_valid  = r_resp_vld;
  assign m_resp_rdata  = r_rdata;
  assign ctl_req_valid = r_valid;
  assign ctl_req_rw    = r_rw;
  assign ctl_req_addr  = r_addr;
  assign ctl_req_wdata = r_wdata;
  assign grant_id      = r_grant;
  assign busy          = (r_state != ST_IDLE);
  assign err           = r_err;

endmodule

// File: tb/tb_ddr1_port_arbiter.sv
// Bench for ddr1_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_ddr1_port_arbiter;

  localparam int N     = 4;
  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int IW    = $clog2(N);
  localparam int WRH   = 6;
  localparam int RDT   = 64;
`ifdef DDR1_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk, rst;
  logic [N-1:0]      m_req_valid, m_req_rw, m_req_accept, m_resp_valid;
  logic [N*AW-1:0]   m_req_addr;
  logic [N*DW-1:0]   m_req_wdata;
  logic [DW-1:0]     m_resp_rdata, ctl_req_wdata, ctl_resp_rdata;
  logic              ctl_req_valid, ctl_req_rw, ctl_req_ack, ctl_resp_valid;
  logic [AW-1:0]     ctl_req_addr;
  logic [IW-1:0]     grant_id;
  logic              busy, err;

  ddr1_port_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .WR_HOLD(WRH), .RD_TIMEOUT(RDT)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_accept(m_req_accept), .m_resp_valid(m_resp_valid),
    .m_resp_rdata(m_resp_rdata), .ctl_req_valid(ctl_req_valid), .ctl_req_rw(ctl_req_rw),
    .ctl_req_addr(ctl_req_addr), .ctl_req_wdata(ctl_req_wdata), .ctl_req_ack(ctl_req_ack),
    .ctl_resp_valid(ctl_resp_valid), .ctl_resp_rdata(ctl_resp_rdata),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, timed from the cycle its ack was taken
  bit            mdl_started = 1'b0;
  bit            mdl_active, mdl_acked, mdl_rw, mdl_err;
  int            mdl_port, mdl_last, mdl_ack_cyc, cyc, pk;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata, mdl_rdata;
  logic [N-1:0]  exp_accept, exp_resp;
  bit            issuing, reading;

  function automatic int pick(input logic [N-1:0] v, input int last);
    if (FIXED && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (v[p] && !(FIXED && p == 0)) return p;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    mdl_active = 0; mdl_acked = 0; mdl_rw = 0; mdl_err = 0;
    mdl_port = 0; mdl_last = N - 1; mdl_ack_cyc = 0;
    mdl_addr = '0; mdl_wdata = '0; mdl_rdata = '0;
  endtask

  initial begin
    cyc = 0; exp_accept = '0; exp_resp = '0;
    mdl_reset();
    forever begin
      @(posedge clk);
      cyc++;
      mdl_started = 1'b1;
      exp_accept  = '0;
      exp_resp    = '0;
      if (rst) begin
        mdl_reset();
      end else begin
        issuing = mdl_active && !mdl_acked;
        reading = mdl_active && mdl_acked && mdl_rw;
        if (ctl_req_ack && !issuing) mdl_err = 1;
        if (ctl_resp_valid && !reading) mdl_err = 1;
        if (!mdl_active) begin
          pk = pick(m_req_valid, mdl_last);
          if (pk >= 0) begin
            mdl_active = 1; mdl_acked = 0; mdl_port = pk;
            if (!(FIXED && pk == 0)) mdl_last = pk;
            mdl_rw    = m_req_rw[pk];
            mdl_addr  = m_req_addr[pk*AW +: AW];
            mdl_wdata = m_req_wdata[pk*DW +: DW];
            exp_accept[pk] = 1'b1;
          end
        end else if (issuing) begin
          if (ctl_req_ack) begin mdl_acked = 1; mdl_ack_cyc = cyc; end
        end else if (mdl_rw) begin
          if (ctl_resp_valid) begin
            mdl_rdata = ctl_resp_rdata; exp_resp[mdl_port] = 1'b1; mdl_active = 0;
          end else if (cyc == mdl_ack_cyc + RDT) begin
            mdl_err = 1; mdl_active = 0;
          end
        end else if (cyc == mdl_ack_cyc + WRH) begin
          mdl_active = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_started) begin
        check("accept",     m_req_accept,  exp_accept);
        check("resp_valid", m_resp_valid,  exp_resp);
        check("resp_rdata", m_resp_rdata,  mdl_rdata);
        check("ctl_valid",  ctl_req_valid, mdl_active && !mdl_acked);
        check("ctl_rw",     ctl_req_rw,    mdl_rw);
        check("ctl_addr",   ctl_req_addr,  mdl_addr);
        check("ctl_wdata",  ctl_req_wdata, mdl_wdata);
        check("grant_id",   grant_id,      mdl_port);
        check("busy",       busy,          mdl_active);
        check("err",        err,           mdl_err);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; m_req_valid = '0; ctl_req_ack = 1'b0; ctl_resp_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_accept(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = m_req_accept[p];
    end
    check("accept_seen", ok, 1'b1);
  endtask

  task automatic wait_any(output int idx);
    bit ok = 1'b0;
    idx = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = |m_req_accept;
    end
    check("accept_any_seen", ok, 1'b1);
    for (int j = 0; j < N; j++) if (m_req_accept[j]) idx = j;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic set_port(input int p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req_rw[p] = rw;
    m_req_addr[p*AW +: AW] = a;
    m_req_wdata[p*DW +: DW] = d;
  endtask

  task automatic req(input int p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_port(p, rw, a, d);
    m_req_valid[p] = 1'b1;
    wait_accept(p);
    m_req_valid[p] = 1'b0;
  endtask

  task automatic ack_once();
    ctl_req_ack = 1'b1;
    @(negedge clk);
    ctl_req_ack = 1'b0;
  endtask

  int n, idx;
  bit saw_resp;
  int exp_order [5];

  initial begin
    rst = 1'b1; m_req_valid = '0; m_req_rw = '0; m_req_addr = '0; m_req_wdata = '0;
    ctl_req_ack = 1'b0; ctl_resp_valid = 1'b0; ctl_resp_rdata = '0;
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ctl_valid", ctl_req_valid, 1'b0);

    // Port 2 write held for WR_HOLD cycles; a short-lived port 3 request is never granted
    req(2, 1'b0, 25'h0123456, 16'hBEEF);
    check("t1_accept", m_req_accept, 4'b0100);
    check("t1_addr", ctl_req_addr, 25'h0123456);
    check("t1_wdata", ctl_req_wdata, 16'hBEEF);
    ack_once();
    set_port(3, 1'b0, 25'h1, 16'h1);
    m_req_valid[3] = 1'b1;
    @(negedge clk);
    m_req_valid[3] = 1'b0;
    wait_idle(n);
    check("t1_hold_cycles", n + 1, 6);
    check("t1_addr_after", ctl_req_addr, 25'h0123456);

    // Port 1 read answered two cycles after the ack
    req(1, 1'b1, 25'h1ABCDEF, 16'h0);
    ack_once();
    @(negedge clk);
    ctl_resp_valid = 1'b1; ctl_resp_rdata = 16'h5A5A;
    @(negedge clk);
    ctl_resp_valid = 1'b0;
    check("t2_resp_valid", m_resp_valid, 4'b0010);
    check("t2_rdata", m_resp_rdata, 16'h5A5A);
    @(negedge clk);
    check("t2_resp_single", m_resp_valid, 4'b0000);
    check("t2_rdata_hold", m_resp_rdata, 16'h5A5A);

    // All ports requesting continuously after reset
    do_reset();
    if (FIXED) exp_order = '{0, 0, 0, 0, 0};
    else       exp_order = '{0, 1, 2, 3, 0};
    for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(32'h100 + p), DW'(32'h1000 + p));
    m_req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      wait_any(idx);
      check("t3_grant", idx, exp_order[t]);
      ack_once();
      check("t3_accept_pulse", m_req_accept, 4'b0000);
      wait_idle(n);
    end
    m_req_valid = '0;

    // Read timeout, then service resumes
    req(3, 1'b1, 25'h0000777, 16'h0);
    ack_once();
    saw_resp = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      saw_resp |= |m_resp_valid;
      n++;
      @(negedge clk);
    end
    check("t4_wait_cycles", n, 64);
    check("t4_err", err, 1'b1);
    check("t4_no_resp", saw_resp, 1'b0);
    req(0, 1'b0, 25'h0000042, 16'h4242);
    check("t4_next_accept", m_req_accept, 4'b0001);
    ack_once();
    wait_idle(n);

    // Spurious ack and response while idle
    do_reset();
    ack_once();
    check("t5_ack_err", err, 1'b1);
    check("t5_ack_busy", busy, 1'b0);
    do_reset();
    check("t5_err_clear", err, 1'b0);
    ctl_resp_valid = 1'b1; ctl_resp_rdata = 16'h1111;
    @(negedge clk);
    ctl_resp_valid = 1'b0;
    check("t5_resp_err", err, 1'b1);
    check("t5_no_resp", m_resp_valid, 4'b0000);
    check("t5_rdata", m_resp_rdata, 16'h0000);
    check("t5_busy", busy, 1'b0);

    // Ack and response together in ISSUE: response dropped
    req(1, 1'b1, 25'h0000999, 16'h0);
    ctl_req_ack = 1'b1; ctl_resp_valid = 1'b1; ctl_resp_rdata = 16'h2222;
    @(negedge clk);
    ctl_req_ack = 1'b0; ctl_resp_valid = 1'b0;
    check("t5_dual_no_resp", m_resp_valid, 4'b0000);
    check("t5_dual_busy", busy, 1'b1);
    ctl_resp_valid = 1'b1; ctl_resp_rdata = 16'h3333;
    @(negedge clk);
    ctl_resp_valid = 1'b0;
    check("t5_late_resp", m_resp_valid, 4'b0010);
    check("t5_late_rdata", m_resp_rdata, 16'h3333);

    // Reset during WAIT_RD
    do_reset();
    req(2, 1'b1, 25'h1555555, 16'h0);
    ack_once();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_a", {m_req_accept, m_resp_valid, m_resp_rdata, ctl_req_valid, ctl_req_rw}, '0);
    check("t6_rst_b", {ctl_req_addr, ctl_req_wdata, grant_id, busy, err}, '0);
    rst = 1'b0;
    set_port(0, 1'b0, 25'h0000010, 16'hA0A0);
    set_port(3, 1'b0, 25'h0000013, 16'hA3A3);
    m_req_valid = 4'b1001;
    wait_any(idx);
    check("t6_first_grant", idx, 0);
    ack_once();
    wait_idle(n);
`ifdef DDR1_ARB_FIXED_PRIO_EN
    for (int t = 0; t < 3; t++) begin
      wait_any(idx);
      check("fp_grant", idx, 0);
      ack_once();
      wait_idle(n);
    end
`endif
    m_req_valid = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
